// File: rtl/seq_divmod_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divmod_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} divmod_state_t;

  localparam int DIVMOD_DEFAULT_WIDTH = 64;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

endpackage

// File: rtl/seq_divmod_if.sv
// Request/result bundle between a divider client (master) and seq_divmod (slave).
// Carries rem_is_zero only when SEQ_DIVMOD_REM_ZERO_FLAG_EN is defined.
interface seq_divmod_if #(
  parameter int DATAWIDTH = seq_divmod_pkg::DIVMOD_DEFAULT_WIDTH
);
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 div_by_zero;
`ifdef SEQ_DIVMOD_REM_ZERO_FLAG_EN
  logic                 rem_is_zero;

  modport master (output start, a, b,
                  input  busy, done, quot, rem, div_by_zero, rem_is_zero);
  modport slave  (input  start, a, b,
                  output busy, done, quot, rem, div_by_zero, rem_is_zero);
`else
  modport master (output start, a, b,
                  input  busy, done, quot, rem, div_by_zero);
  modport slave  (input  start, a, b,
                  output busy, done, quot, rem, div_by_zero);
`endif
endinterface

// File: rtl/seq_divmod_step.sv
// One restoring-division iteration: shift {r,q} left, subtract b, keep the result if non-negative.
module divmod_step #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] r,
  input  logic [DATAWIDTH-1:0] q,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] r_next,
  output logic [DATAWIDTH-1:0] q_next
);
  logic [DATAWIDTH:0] r_sh;
  logic [DATAWIDTH:0] trial;

  assign r_sh  = {r, q[DATAWIDTH-1]};
  assign trial = r_sh - {1'b0, b};

  // r < b holds between iterations, so a non-negative trial always fits in DATAWIDTH bits
  assign r_next = trial[DATAWIDTH] ? r_sh[DATAWIDTH-1:0] : trial[DATAWIDTH-1:0];
  assign q_next = {q[DATAWIDTH-2:0], ~trial[DATAWIDTH]};
endmodule

// File: rtl/seq_divmod.sv
// Multi-cycle unsigned radix-2 restoring divider with start/done handshake.
// Optional SEQ_DIVMOD_REM_ZERO_FLAG_EN adds a registered rem_is_zero flag.
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int DATAWIDTH = DIVMOD_DEFAULT_WIDTH
) (
  input  logic        Clk,
  input  logic        Rst,
  seq_divmod_if.slave bus
);
  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

  logic [1:0]           state_reg;
  logic [DATAWIDTH-1:0] r_reg;
  logic [DATAWIDTH-1:0] q_reg;
  logic [DATAWIDTH-1:0] b_reg;
  logic [CW-1:0]        cnt_reg;
  logic [DATAWIDTH-1:0] quot_reg;
  logic [DATAWIDTH-1:0] rem_reg;
  logic                 dbz_reg;
  logic [DATAWIDTH-1:0] r_next;
  logic [DATAWIDTH-1:0] q_next;

  divmod_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b      (b_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

`ifdef SEQ_DIVMOD_REM_ZERO_FLAG_EN
  logic rz_reg;
  assign bus.rem_is_zero = rz_reg;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= S_IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
`ifdef SEQ_DIVMOD_REM_ZERO_FLAG_EN
      rz_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_reg <= S_RUN;
            r_reg     <= '0;
            q_reg     <= bus.a;
            b_reg     <= bus.b;
            // Zero divisor spends a single RUN cycle, giving done one edge after acceptance
            if (bus.b == '0) begin
              cnt_reg <= CNT_LAST;
            end else begin
              cnt_reg <= '0;
              dbz_reg <= 1'b0;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_DONE;
            if (b_reg == '0) begin
              quot_reg <= '1;
              rem_reg  <= q_reg;
              dbz_reg  <= 1'b1;
`ifdef SEQ_DIVMOD_REM_ZERO_FLAG_EN
              rz_reg   <= 1'b0;
`endif
            end else begin
              quot_reg <= q_next;
              rem_reg  <= r_next;
`ifdef SEQ_DIVMOD_REM_ZERO_FLAG_EN
              rz_reg   <= (r_next == '0);
`endif
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_reg == S_RUN);
  assign bus.done        = (state_reg == S_DONE);
  assign bus.quot        = quot_reg;
  assign bus.rem         = rem_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
